// File: rtl/spi_pin_expander.sv
// SPI mode-0 slave exposing WIDTH GPIO pins: write pin_out/pin_oe, read pin_in/pin_oe.
// Build macro PIN_CHANGE_IRQ_EN adds a sticky pin-change register (command 0x05) and irq_n.
`timescale 1ns/1ps
module spi_pin_expander #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             spi_sck,
   input  logic             spi_ss_n,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic             spi_miso_oe,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] pin_out,
   output logic [WIDTH-1:0] pin_oe
`ifdef PIN_CHANGE_IRQ_EN
   ,
   output logic             irq_n
`endif
);
   // state  | meaning
   // IDLE   | slave not selected, waiting for ss_n falling edge
   // CMD    | shifting in the 8-bit command
   // DATA   | WIDTH-bit data phase (write shift-in or read shift-out)
   // IGNORE | unknown command or data phase done; wait for ss_n high
   typedef enum logic [1:0] {IDLE, CMD, DATA, IGNORE} state_t;

`ifdef PIN_CHANGE_IRQ_EN
   localparam logic [7:0] MAX_CMD = 8'h05;
`else
   localparam logic [7:0] MAX_CMD = 8'h04;
`endif
   localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

   logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
   logic                   sck_s, ss_s, mosi_s, sck_prev, ss_prev;
   logic                   sck_rise, sck_fall, ss_fall;
   logic                   started, armed;

   state_t           state;
   logic [4:0]       bit_cnt;
   logic [6:0]       cmd_sr;
   logic [2:0]       op;
   logic [WIDTH-2:0] data_sr;
   logic [WIDTH-1:0] shreg, snap_src, data_next;
   logic [7:0]       cmd_full;
   logic             cmd_done, cmd_valid, op_read;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sck_sync  <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sck_prev  <= 1'b0;
         ss_prev   <= 1'b1;
         started   <= 1'b0;
         armed     <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         sck_prev  <= sck_s;
         ss_prev   <= ss_s;
         started   <= 1'b1;
         // The reset-forced 1s draining out of the ss_n chain must not look like a select.
         if (started && ss_sync[0]) armed <= 1'b1;
      end
   end

   assign sck_s       = sck_sync[SYNC_STAGES-1];
   assign ss_s        = ss_sync[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync[SYNC_STAGES-1];
   assign sck_rise    = sck_s & ~sck_prev;
   assign sck_fall    = ~sck_s & sck_prev;
   assign ss_fall     = armed & ss_prev & ~ss_s;
   assign spi_miso_oe = ~ss_s;

   assign cmd_full  = {cmd_sr, mosi_s};
   assign cmd_done  = (state == CMD) && sck_rise && (bit_cnt == 5'd7);
   assign cmd_valid = (cmd_full != 8'h00) && (cmd_full <= MAX_CMD);
   assign op_read   = (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
   assign data_next = {data_sr, mosi_s};

`ifdef PIN_CHANGE_IRQ_EN
   logic [WIDTH-1:0] pin_s1, pin_s2, pin_s3, chg;
   logic             snap_chg;

   assign snap_chg = cmd_done && !ss_s && (cmd_full == 8'h05);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pin_s1 <= '0;
         pin_s2 <= '0;
         pin_s3 <= '0;
         chg    <= '0;
      end else begin
         pin_s1 <= pin_in;
         pin_s2 <= pin_s1;
         pin_s3 <= pin_s2;
         // Clear only what the read captured; a change landing this cycle stays set.
         chg    <= (chg & ~(snap_chg ? chg : '0)) | (pin_s2 ^ pin_s3);
      end
   end

   assign irq_n = ~|chg;
`endif

   always_comb begin
      snap_src = '0;
      case (cmd_full)
         8'h03:   snap_src = pin_in;
         8'h04:   snap_src = pin_oe;
`ifdef PIN_CHANGE_IRQ_EN
         8'h05:   snap_src = chg;
`endif
         default: snap_src = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         cmd_sr   <= '0;
         op       <= '0;
         data_sr  <= '0;
         shreg    <= '0;
         pin_out  <= '0;
         pin_oe   <= '0;
         spi_miso <= 1'b0;
      end else if (ss_s) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         spi_miso <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ss_fall) begin
                  state   <= CMD;
                  bit_cnt <= '0;
               end
            end
            CMD: begin
               if (sck_rise) begin
                  cmd_sr  <= cmd_full[6:0];
                  bit_cnt <= bit_cnt + 5'd1;
                  if (cmd_done) begin
                     bit_cnt <= '0;
                     op      <= cmd_full[2:0];
                     shreg   <= snap_src;
                     state   <= cmd_valid ? DATA : IGNORE;
                  end
               end
            end
            DATA: begin
               if (sck_fall && op_read) begin
                  spi_miso <= shreg[WIDTH-1];
                  shreg    <= {shreg[WIDTH-2:0], 1'b0};
               end
               if (sck_rise) begin
                  data_sr <= data_next[WIDTH-2:0];
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == LAST_BIT) begin
                     state    <= IGNORE;
                     spi_miso <= 1'b0;
                     if (op == 3'd1) pin_out <= data_next;
                     if (op == 3'd2) pin_oe  <= data_next;
                  end
               end
            end
            default: spi_miso <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_pin_expander.sv
// Directed bench for spi_pin_expander: bit-banged SPI master, hand-computed expectations.
`timescale 1ns/1ps
module tb_spi_pin_expander;
   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             spi_sck = 1'b0;
   logic             spi_ss_n = 1'b1;
   logic             spi_mosi = 1'b0;
   logic             spi_miso, spi_miso_oe;
   logic [WIDTH-1:0] pin_in = '0;
   logic [WIDTH-1:0] pin_out, pin_oe;
`ifdef PIN_CHANGE_IRQ_EN
   logic             irq_n;
`endif

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] tx[4];
   logic [7:0] rx[4];
   logic       oe_mid;

   always #5 clk = ~clk;

   spi_pin_expander #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .spi_sck(spi_sck), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe)
`ifdef PIN_CHANGE_IRQ_EN
      , .irq_n(irq_n)
`endif
   );

   task automatic half();
      repeat (5) @(negedge clk);
   endtask

   // MISO is sampled just before each rising edge, as a mode-0 master would.
   task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
      r = '0;
      for (int i = 7; i > 7 - nb; i--) begin
         spi_mosi = b[i];
         half();
         r[i] = spi_miso;
         spi_sck = 1'b1;
         half();
         spi_sck = 1'b0;
      end
   endtask

   task automatic spi_txn(input int nb);
      spi_ss_n = 1'b0;
      half();
      oe_mid = spi_miso_oe;
      for (int k = 0; k < nb; k++) spi_bits(tx[k], 8, rx[k]);
      half();
      spi_ss_n = 1'b1;
      spi_mosi = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (pin_out !== 16'h0000) begin n_bad++; $display("FAIL reset_pin_out got=%h want=0000", pin_out); end
      n_cmp++; if (pin_oe !== 16'h0000) begin n_bad++; $display("FAIL reset_pin_oe got=%h want=0000", pin_oe); end
      n_cmp++; if (spi_miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso got=%b want=0", spi_miso); end
      n_cmp++; if (spi_miso_oe !== 1'b0) begin n_bad++; $display("FAIL reset_miso_oe got=%b want=0", spi_miso_oe); end
`ifdef PIN_CHANGE_IRQ_EN
      n_cmp++; if (irq_n !== 1'b1) begin n_bad++; $display("FAIL reset_irq_n got=%b want=1", irq_n); end
`endif
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_write_oe();
      tx[0] = 8'h02; tx[1] = 8'hFF; tx[2] = 8'h00;
      spi_txn(3);
      n_cmp++; if (oe_mid !== 1'b1) begin n_bad++; $display("FAIL oe_during_txn got=%b want=1", oe_mid); end
      n_cmp++; if (spi_miso_oe !== 1'b0) begin n_bad++; $display("FAIL oe_after_txn got=%b want=0", spi_miso_oe); end
      n_cmp++; if (pin_oe !== 16'hFF00) begin n_bad++; $display("FAIL wr_oe got=%h want=ff00", pin_oe); end
      n_cmp++; if (pin_out !== 16'h0000) begin n_bad++; $display("FAIL wr_oe_out_kept got=%h want=0000", pin_out); end
      n_cmp++; if ({rx[0], rx[1], rx[2]} !== 24'h0) begin n_bad++; $display("FAIL wr_miso_zero got=%h want=000000", {rx[0], rx[1], rx[2]}); end
   endtask

   task automatic test_write_out();
      tx[0] = 8'h01; tx[1] = 8'h12; tx[2] = 8'h34;
      spi_txn(3);
      n_cmp++; if (pin_out !== 16'h1234) begin n_bad++; $display("FAIL wr_out got=%h want=1234", pin_out); end
      n_cmp++; if (pin_oe !== 16'hFF00) begin n_bad++; $display("FAIL wr_out_oe_kept got=%h want=ff00", pin_oe); end
   endtask

   task automatic test_read_oe();
      tx[0] = 8'h04; tx[1] = 8'h00; tx[2] = 8'h00;
      spi_txn(3);
      n_cmp++; if (rx[0] !== 8'h00) begin n_bad++; $display("FAIL rd_oe_cmd_byte got=%h want=00", rx[0]); end
      n_cmp++; if ({rx[1], rx[2]} !== 16'hFF00) begin n_bad++; $display("FAIL rd_oe got=%h want=ff00", {rx[1], rx[2]}); end
   endtask

   task automatic test_read_pin();
      pin_in = 16'hA5C3;
      tx[0] = 8'h03; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h00;
      spi_txn(4);
      n_cmp++; if (rx[1] !== 8'hA5) begin n_bad++; $display("FAIL rd_pin_hi got=%h want=a5", rx[1]); end
      n_cmp++; if (rx[2] !== 8'hC3) begin n_bad++; $display("FAIL rd_pin_lo got=%h want=c3", rx[2]); end
      n_cmp++; if (rx[3] !== 8'h00) begin n_bad++; $display("FAIL rd_pin_extra got=%h want=00", rx[3]); end
      n_cmp++; if (pin_out !== 16'h1234) begin n_bad++; $display("FAIL rd_pin_out_kept got=%h want=1234", pin_out); end
   endtask

   task automatic test_abort();
      logic [7:0] junk;
      spi_ss_n = 1'b0;
      half();
      spi_bits(8'h01, 8, junk);
      spi_bits(8'hAB, 8, junk);
      spi_bits(8'hF0, 4, junk);
      half();
      spi_ss_n = 1'b1;
      repeat (10) @(negedge clk);
      n_cmp++; if (pin_out !== 16'h1234) begin n_bad++; $display("FAIL abort_out_kept got=%h want=1234", pin_out); end
      tx[0] = 8'h01; tx[1] = 8'h56; tx[2] = 8'h78;
      spi_txn(3);
      n_cmp++; if (pin_out !== 16'h5678) begin n_bad++; $display("FAIL after_abort_wr got=%h want=5678", pin_out); end
   endtask

   task automatic test_unknown();
      tx[0] = 8'h7E; tx[1] = 8'hFF; tx[2] = 8'hFF;
      spi_txn(3);
      n_cmp++; if (pin_out !== 16'h5678) begin n_bad++; $display("FAIL unk_out_kept got=%h want=5678", pin_out); end
      n_cmp++; if (pin_oe !== 16'hFF00) begin n_bad++; $display("FAIL unk_oe_kept got=%h want=ff00", pin_oe); end
      n_cmp++; if ({rx[0], rx[1], rx[2]} !== 24'h0) begin n_bad++; $display("FAIL unk_miso got=%h want=000000", {rx[0], rx[1], rx[2]}); end
`ifndef PIN_CHANGE_IRQ_EN
      tx[0] = 8'h05; tx[1] = 8'hAA; tx[2] = 8'h55;
      spi_txn(3);
      n_cmp++; if ({rx[1], rx[2]} !== 16'h0) begin n_bad++; $display("FAIL cmd05_ignored_miso got=%h want=0000", {rx[1], rx[2]}); end
      n_cmp++; if (pin_out !== 16'h5678) begin n_bad++; $display("FAIL cmd05_out_kept got=%h want=5678", pin_out); end
`endif
   endtask

   task automatic test_back_to_back();
      tx[0] = 8'h02; tx[1] = 8'h0F; tx[2] = 8'h0F;
      spi_txn(3);
      tx[0] = 8'h04; tx[1] = 8'h00; tx[2] = 8'h00;
      spi_txn(3);
      n_cmp++; if (pin_oe !== 16'h0F0F) begin n_bad++; $display("FAIL b2b_oe got=%h want=0f0f", pin_oe); end
      n_cmp++; if ({rx[1], rx[2]} !== 16'h0F0F) begin n_bad++; $display("FAIL b2b_rd_oe got=%h want=0f0f", {rx[1], rx[2]}); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] junk;
      spi_ss_n = 1'b0;
      half();
      spi_bits(8'h01, 8, junk);
      spi_bits(8'hFF, 5, junk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (pin_out !== 16'h0000) begin n_bad++; $display("FAIL rstmid_out got=%h want=0000", pin_out); end
      n_cmp++; if (pin_oe !== 16'h0000) begin n_bad++; $display("FAIL rstmid_oe got=%h want=0000", pin_oe); end
      // ss_n never rose after reset: this whole frame must be ignored.
      spi_bits(8'h01, 8, junk);
      spi_bits(8'hFF, 8, junk);
      spi_bits(8'hFF, 8, junk);
      half();
      spi_ss_n = 1'b1;
      repeat (10) @(negedge clk);
      n_cmp++; if (pin_out !== 16'h0000) begin n_bad++; $display("FAIL rstmid_no_fresh_ss got=%h want=0000", pin_out); end
      tx[0] = 8'h01; tx[1] = 8'h00; tx[2] = 8'h0F;
      spi_txn(3);
      n_cmp++; if (pin_out !== 16'h000F) begin n_bad++; $display("FAIL rstmid_recover got=%h want=000f", pin_out); end
   endtask

`ifdef PIN_CHANGE_IRQ_EN
   task automatic test_irq();
      tx[0] = 8'h05; tx[1] = 8'h00; tx[2] = 8'h00;
      spi_txn(3);
      n_cmp++; if (irq_n !== 1'b1) begin n_bad++; $display("FAIL irq_cleared got=%b want=1", irq_n); end
      pin_in[3] = ~pin_in[3];
      repeat (3) @(negedge clk);
      n_cmp++; if (irq_n !== 1'b0) begin n_bad++; $display("FAIL irq_assert got=%b want=0", irq_n); end
      spi_txn(3);
      n_cmp++; if ({rx[1], rx[2]} !== 16'h0008) begin n_bad++; $display("FAIL irq_rd got=%h want=0008", {rx[1], rx[2]}); end
      n_cmp++; if (irq_n !== 1'b1) begin n_bad++; $display("FAIL irq_release got=%b want=1", irq_n); end
   endtask
`endif

   initial begin
      test_reset();
      test_write_oe();
      test_write_out();
      test_read_oe();
      test_read_pin();
      test_abort();
      test_unknown();
      test_back_to_back();
      test_reset_mid();
`ifdef PIN_CHANGE_IRQ_EN
      test_irq();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
